// File: rtl/inst_cache_dm.sv
// Direct-mapped instruction cache with multi-beat line refill and full flush.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module inst_cache_dm #(
    parameter int WORD_SIZE      = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int NUM_LINES      = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [WORD_SIZE-1:0]  resp_inst,
    input  logic                  flush,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [WORD_SIZE-1:0]  mem_resp_data,
    output logic                  busy
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int BO_W  = $clog2(WORD_SIZE / 8);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - BO_W;
    localparam int WA_W  = ADDR_WIDTH - BO_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_FILL_REQ  = 3'd2;
    localparam logic [2:0] S_FILL_DATA = 3'd3;
    localparam logic [2:0] S_RESPOND   = 3'd4;
    localparam logic [2:0] S_FLUSH     = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [WA_W-1:0]      addr_q;
    logic [NUM_LINES-1:0] valid_q;
    logic                 flush_pending_q;
    logic [OFF_W-1:0]     beat_q;
    logic [IDX_W-1:0]     cnt_q;
    logic [WORD_SIZE-1:0] word_q;

    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0] data_q [NUM_LINES][WORDS_PER_LINE];

    logic [TAG_W-1:0] cur_tag;
    logic [IDX_W-1:0] cur_idx;
    logic [OFF_W-1:0] cur_off;
    logic             hit;
    logic             accept;
    logic             last_beat;
    logic             last_line;
    logic             unused_byte_off;

    assign cur_tag = addr_q[WA_W-1 -: TAG_W];
    assign cur_idx = addr_q[OFF_W +: IDX_W];
    assign cur_off = addr_q[OFF_W-1:0];
    assign hit     = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    // Byte-offset bits of the fetch address carry no information.
    assign unused_byte_off = ^req_addr[BO_W-1:0];

    assign req_ready = (state_q == S_IDLE) && !flush && !flush_pending_q;
    assign accept    = req_valid && req_ready;
    assign last_beat = (beat_q == OFF_W'(WORDS_PER_LINE - 1));
    assign last_line = (cnt_q == IDX_W'(NUM_LINES - 1));
    assign busy      = (state_q != S_IDLE);

    assign mem_req_valid = (state_q == S_FILL_REQ);
    assign mem_req_addr  = mem_req_valid ?
        {addr_q[WA_W-1:OFF_W], {(OFF_W + BO_W){1'b0}}} : '0;

    // Response is driven straight from the FSM state: one pulse per request.
    always_comb begin
        resp_valid = 1'b0;
        resp_inst  = '0;
        if (state_q == S_LOOKUP && hit) begin
            resp_valid = 1'b1;
            resp_inst  = data_q[cur_idx][cur_off];
        end else if (state_q == S_RESPOND) begin
            resp_valid = 1'b1;
            resp_inst  = word_q;
        end
    end

    // Next-state logic of the lookup/refill/flush controller.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush || flush_pending_q) state_d = S_FLUSH;
                else if (req_valid)           state_d = S_LOOKUP;
            end
            S_LOOKUP:    state_d = hit ? S_IDLE : S_FILL_REQ;
            S_FILL_REQ:  if (mem_req_ready) state_d = S_FILL_DATA;
            S_FILL_DATA: if (mem_resp_valid && last_beat) state_d = S_RESPOND;
            S_RESPOND:   state_d = S_IDLE;
            S_FLUSH:     if (last_line) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Control state, valid bits, counters and the captured response word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
            beat_q          <= '0;
            cnt_q           <= '0;
            word_q          <= '0;
        end else begin
            state_q <= state_d;
            if (accept) addr_q <= req_addr[ADDR_WIDTH-1:BO_W];
            if (state_q == S_FLUSH && last_line)
                flush_pending_q <= 1'b0;
            else if (flush && state_q != S_IDLE && state_q != S_FLUSH)
                flush_pending_q <= 1'b1;
            if (state_q == S_IDLE && (flush || flush_pending_q))
                cnt_q <= '0;
            if (state_q == S_FLUSH) begin
                valid_q[cnt_q] <= 1'b0;
                cnt_q          <= cnt_q + 1'b1;
            end
            if (state_q == S_FILL_REQ && mem_req_ready)
                beat_q <= '0;
            if (state_q == S_FILL_DATA && mem_resp_valid) begin
                beat_q <= beat_q + 1'b1;
                if (beat_q == cur_off) word_q <= mem_resp_data;
                if (last_beat) valid_q[cur_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays hold no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (state_q == S_FILL_DATA && mem_resp_valid) begin
            data_q[cur_idx][beat_q] <= mem_resp_data;
            if (last_beat) tag_q[cur_idx] <= cur_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    // Saturating lookup statistics, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == S_LOOKUP) begin
            if (hit && hit_count != '1)
                hit_count <= hit_count + 1'b1;
            if (!hit && miss_count != '1)
                miss_count <= miss_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache_dm.sv
// Directed self-checking bench for inst_cache_dm (default parameters).
// Memory side is driven directly by the scenario tasks.
module tb_inst_cache_dm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    inst_cache_dm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_inst      (resp_inst),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Full miss transaction: request, lookup, handshake, four beats, respond.
    task automatic miss_seq(input logic [31:0] a, input logic [31:0] d0,
                            output logic lk_rv, output logic mrv,
                            output logic [31:0] maddr, output logic rv,
                            output logic [31:0] ri, output logic rv_after);
        @(negedge clk); req_valid = 1'b1; req_addr = a;
        @(negedge clk); req_valid = 1'b0; #1 lk_rv = resp_valid;
        @(negedge clk); #1 mrv = mem_req_valid; maddr = mem_req_addr;
        mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = d0 + 32'(i);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        #1 rv = resp_valid; ri = resp_inst;
        @(negedge clk); #1 rv_after = resp_valid;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++;
            $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_inst !== 32'h0) begin errors++;
            $display("FAIL reset_resp_inst got %h exp 0", resp_inst); end
        checks++; if (mem_req_valid !== 1'b0) begin errors++;
            $display("FAIL reset_mem_req_valid got %b exp 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++;
            $display("FAIL reset_mem_req_addr got %h exp 0", mem_req_addr); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got %b exp 0", busy); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++;
            $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_miss();
        logic lk, mrv, rv, rva; logic [31:0] ma, ri;
        miss_seq(32'h40, 32'hA0, lk, mrv, ma, rv, ri, rva);
        checks++; if (lk !== 1'b0) begin errors++;
            $display("FAIL miss_lookup_resp got %b exp 0", lk); end
        checks++; if (mrv !== 1'b1) begin errors++;
            $display("FAIL miss_mem_req_valid got %b exp 1", mrv); end
        checks++; if (ma !== 32'h40) begin errors++;
            $display("FAIL miss_mem_req_addr got %h exp 40", ma); end
        checks++; if (rv !== 1'b1 || ri !== 32'hA0) begin errors++;
            $display("FAIL miss_resp got v=%b d=%h exp v=1 d=a0", rv, ri); end
        checks++; if (rva !== 1'b0) begin errors++;
            $display("FAIL miss_resp_pulse got %b exp 0", rva); end
    endtask

    task automatic test_hit(input logic [31:0] a, input logic [31:0] exp);
        logic rv, mrv, rv2, bz; logic [31:0] ri;
        @(negedge clk); req_valid = 1'b1; req_addr = a;
        @(negedge clk); req_valid = 1'b0;
        #1 rv = resp_valid; ri = resp_inst; mrv = mem_req_valid;
        @(negedge clk); #1 rv2 = resp_valid; bz = busy;
        checks++; if (rv !== 1'b1 || ri !== exp) begin errors++;
            $display("FAIL hit_resp a=%h got v=%b d=%h exp v=1 d=%h",
                     a, rv, ri, exp); end
        checks++; if (mrv !== 1'b0 || rv2 !== 1'b0 || bz !== 1'b0) begin
            errors++;
            $display("FAIL hit_after a=%h got mrv=%b rv=%b busy=%b exp 0 0 0",
                     a, mrv, rv2, bz); end
    endtask

    task automatic test_evict();
        logic lk, mrv, rv, rva; logic [31:0] ma, ri;
        miss_seq(32'h0001_0040, 32'hB0, lk, mrv, ma, rv, ri, rva);
        checks++; if (lk !== 1'b0 || mrv !== 1'b1 || ma !== 32'h0001_0040)
        begin errors++;
            $display("FAIL evict_miss got lk=%b mrv=%b addr=%h exp 0 1 10040",
                     lk, mrv, ma); end
        checks++; if (rv !== 1'b1 || ri !== 32'hB0) begin errors++;
            $display("FAIL evict_resp got v=%b d=%h exp v=1 d=b0", rv, ri); end
        miss_seq(32'h40, 32'hA0, lk, mrv, ma, rv, ri, rva);
        checks++; if (lk !== 1'b0 || mrv !== 1'b1 || ma !== 32'h40) begin
            errors++;
            $display("FAIL evict_refetch got lk=%b mrv=%b addr=%h exp 0 1 40",
                     lk, mrv, ma); end
        checks++; if (rv !== 1'b1 || ri !== 32'hA0) begin errors++;
            $display("FAIL evict_refetch_resp got v=%b d=%h exp 1 a0", rv, ri);
        end
    endtask

    task automatic test_stall();
        logic bad; bad = 1'b0;
        @(negedge clk); req_valid = 1'b1; req_addr = 32'h88;
        @(negedge clk); req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h80 ||
                req_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad) begin errors++;
            $display("FAIL stall_hold got mrv=%b addr=%h rdy=%b busy=%b exp 1 80 0 1",
                     mem_req_valid, mem_req_addr, req_ready, busy); end
        mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hC0 + 32'(i);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0; #1;
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'hC2) begin
            errors++;
            $display("FAIL stall_resp got v=%b d=%h exp 1 c2",
                     resp_valid, resp_inst); end
        @(negedge clk);
    endtask

    task automatic test_flush();
        int n; logic lk, mrv, rv, rva; logic [31:0] ma, ri;
        @(negedge clk); req_valid = 1'b1; req_addr = 32'h104;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hD0 + 32'(i);
            flush = (i == 1);
            @(negedge clk);
        end
        flush = 1'b0; mem_resp_valid = 1'b0; #1;
        checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'hD1) begin
            errors++;
            $display("FAIL flush_refill_resp got v=%b d=%h exp 1 d1",
                     resp_valid, resp_inst); end
        @(negedge clk); #1;
        checks++; if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pending got rdy=%b rv=%b exp 0 0",
                     req_ready, resp_valid); end
        n = 0;
        @(negedge clk); #1;
        while (busy === 1'b1 && n < 3000) begin
            n++; @(negedge clk); #1;
        end
        checks++; if (n != 1024) begin errors++;
            $display("FAIL flush_cycles got %0d exp 1024", n); end
        miss_seq(32'h44, 32'hE0, lk, mrv, ma, rv, ri, rva);
        checks++; if (lk !== 1'b0 || mrv !== 1'b1 || ri !== 32'hE1) begin
            errors++;
            $display("FAIL flush_then_miss got lk=%b mrv=%b d=%h exp 0 1 e1",
                     lk, mrv, ri); end
    endtask

    task automatic test_reset_mid();
        logic lk, mrv, rv, rva; logic [31:0] ma, ri;
        @(negedge clk); req_valid = 1'b1; req_addr = 32'h200;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); mem_req_ready = 1'b1;
        @(negedge clk); mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hF0;
        @(negedge clk); mem_resp_valid = 1'b0; rst_n = 1'b0; #1;
        checks++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 ||
                      resp_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_out got busy=%b mrv=%b rv=%b addr=%h exp 0 0 0 0",
                     busy, mem_req_valid, resp_valid, mem_req_addr); end
        @(negedge clk); rst_n = 1'b1;
        miss_seq(32'h44, 32'hE0, lk, mrv, ma, rv, ri, rva);
        checks++; if (lk !== 1'b0 || mrv !== 1'b1 || ma !== 32'h40) begin
            errors++;
            $display("FAIL midreset_miss got lk=%b mrv=%b addr=%h exp 0 1 40",
                     lk, mrv, ma); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        test_reset();
        test_miss();
        test_hit(32'h44, 32'hA1);
        test_hit(32'h4C, 32'hA3);
        test_evict();
        test_stall();
        test_hit(32'h80, 32'hC0);
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
